pc_controller: RTL
==================

Name: pc_controller

Overview:
- Sequences the program counter register: generates its enable and next-address inputs from run mode, hazard stalls and control-flow redirects.
- Sits between the debug/run-control unit, the hazard/branch logic and the PC register.
- Supports continuous run, single-step and halt-with-pipeline-drain.
- Reports status and a cycle count back to the debug unit.

Parameters:
NB_ADDR, 7, width of PC address (matches PC register NB_DATA)
PC_INC, 1, increment added per sequential fetch
DRAIN_CYCLES, 4, cycles run after HALT fetch so in-flight instructions retire
NB_CYCLES, 32, width of executed-cycle counter

Ports:
clock  in  1  system clock; all controller state updates on rising edge
reset  in  1  asynchronous, active-low reset (reset=0 resets)
run_i  in  1  1-cycle pulse: start continuous execution
step_i  in  1  1-cycle pulse: execute one cycle (single-step)
stall_i  in  1  hazard unit stall request; freezes PC
jump_i  in  1  unconditional jump redirect valid
jump_addr_i  in  NB_ADDR  jump target
branch_taken_i  in  1  resolved taken branch
branch_addr_i  in  NB_ADDR  branch target
halt_i  in  1  HALT opcode detected at fetch
pc_addr_i  in  NB_ADDR  current PC register output
pc_enable_o  out  1  enable to PC register
pc_next_o  out  NB_ADDR  next address to PC register
flush_o  out  1  flush IF/ID on redirect
pipe_enable_o  out  1  enable for remaining pipeline stages
running_o  out  1  high in RUN/STEP/DRAIN
done_o  out  1  high in DONE
cycle_count_o  out  NB_CYCLES  executed-cycle count

Behaviour:
- Reset (async assert, sync release) forces state IDLE, cycle_count=0 and drain counter=0.
- During reset, all outputs are 0 except pc_next_o = pc_addr_i + PC_INC.
- States: IDLE, RUN, STEP, DRAIN, DONE.
- IDLE:
  - run_i -> RUN.
  - step_i -> STEP.
  - run_i and step_i in the same cycle -> RUN.
- RUN: "active cycle" every cycle; halt_i -> DRAIN, loading drain counter with DRAIN_CYCLES-1.
- STEP: exactly one active cycle.
  - Next state is IDLE, or DRAIN if halt_i is high in that cycle.
  - If stall_i is high in that cycle, remain in STEP until a non-stalled cycle; PC still advances exactly once.
- DRAIN: pc_enable_o=0, pipe_enable_o=1.
  - Counter decrements each cycle; at 0 -> DONE.
  - Redirects are ignored.
- DONE: sticky; all enables 0; only reset exits.
- Active cycle outputs:
  - pipe_enable_o=1.
  - pc_enable_o = !stall_i && !halt_i; the PC holds on the HALT address.
- Next-address priority is combinational (zero latency):
  - jump_i -> jump_addr_i
  - else branch_taken_i -> branch_addr_i
  - else pc_addr_i + PC_INC, truncated to NB_ADDR (wraps 2^NB_ADDR-1 -> 0 when PC_INC=1).
- flush_o = active && (jump_i || branch_taken_i) && !stall_i.
- Redirect with stall_i: redirect is not taken; the source must hold it until unstalled.
- cycle_count increments in every cycle with pipe_enable_o=1 and wraps at 2^NB_CYCLES.
- run_i or step_i outside IDLE is ignored.
- Reset mid-RUN or mid-DRAIN returns to IDLE immediately (asynchronous), without waiting for a clock edge.

Test Plan:
- Reset pulse low, then run_i with pc_addr_i looping 0..5 -> pc_enable_o=1 each cycle, pc_next_o=1..6, running_o=1, cycle_count increments by 1 per cycle.
- RUN with jump_i=1 and branch_taken_i=1 simultaneously, jump_addr_i=0x20, branch_addr_i=0x40 -> pc_next_o=0x20, flush_o=1. Repeat with stall_i=1 -> pc_enable_o=0, flush_o=0.
- pc_addr_i=0x7F, PC_INC=1 in RUN -> pc_next_o=0x00.
- IDLE, step_i pulse with stall_i high for 2 cycles -> stays in STEP 3 cycles, pc_enable_o high only in 3rd cycle, then IDLE; cycle_count=3.
- RUN, halt_i=1 at PC=0x0A -> pc_enable_o=0 immediately, 4 DRAIN cycles with pipe_enable_o=1, then done_o=1 held. Subsequent run_i/step_i have no effect.
- Assert reset low mid-DRAIN between clock edges -> state IDLE, done_o=0, cycle_count=0 before the next edge.

Source files
------------

// File: rtl/pc_controller_if.sv
// pc_controller_if
//   Bundles the PC-register side of the program counter controller: the
//   redirect requests from the hazard/branch logic, the current PC fed back
//   from the PC register, and the enable/next-address/flush the controller
//   drives in return.
//   Signals:
//     jump_i, jump_addr_i            unconditional jump redirect and target
//     branch_taken_i, branch_addr_i  resolved taken branch and target
//     pc_addr_i                      current PC register output
//     pc_enable_o, pc_next_o         enable and next address to PC register
//     flush_o                        IF/ID flush on a taken redirect
//   The master modport is the controller's view; slave is everything else.
interface pc_controller_if #(
    parameter int unsigned NB_ADDR = 7
);
    logic               jump_i;
    logic [NB_ADDR-1:0] jump_addr_i;
    logic               branch_taken_i;
    logic [NB_ADDR-1:0] branch_addr_i;
    logic [NB_ADDR-1:0] pc_addr_i;
    logic               pc_enable_o;
    logic [NB_ADDR-1:0] pc_next_o;
    logic               flush_o;

    modport master (
        input  jump_i,
        input  jump_addr_i,
        input  branch_taken_i,
        input  branch_addr_i,
        input  pc_addr_i,
        output pc_enable_o,
        output pc_next_o,
        output flush_o
    );

    modport slave (
        output jump_i,
        output jump_addr_i,
        output branch_taken_i,
        output branch_addr_i,
        output pc_addr_i,
        input  pc_enable_o,
        input  pc_next_o,
        input  flush_o
    );
endinterface

// File: rtl/pc_controller.sv
// pc_controller
//   Sequences the program counter register: continuous run, single-step and
//   halt with pipeline drain. Drives the PC enable / next address, the IF/ID
//   flush and the enable for the rest of the pipeline, and reports status and
//   an executed-cycle count to the debug unit.
//   Ports:
//     clock          rising-edge clock
//     reset          asynchronous active-low reset
//     run_i, step_i  1-cycle run / single-step requests (honoured in IDLE only)
//     stall_i        hazard stall, freezes the PC
//     halt_i         HALT opcode seen at fetch
//     pc_bus         PC-register side bundle (redirects, pc_addr, enable/next/flush)
//     pipe_enable_o  enable for the remaining pipeline stages
//     running_o      high in RUN, STEP and DRAIN
//     done_o         high once the drain after HALT has finished
//     cycle_count_o  number of cycles with pipe_enable_o high (wraps)
module pc_controller #(
    parameter int unsigned NB_ADDR      = 7,
    parameter int unsigned PC_INC       = 1,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned NB_CYCLES    = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run_i,
    input  logic                 step_i,
    input  logic                 stall_i,
    input  logic                 halt_i,
    pc_controller_if.master      pc_bus,
    output logic                 pipe_enable_o,
    output logic                 running_o,
    output logic                 done_o,
    output logic [NB_CYCLES-1:0] cycle_count_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_STEP  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int unsigned NB_DRAIN = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

    logic [2:0]           state_q, state_d;
    logic [NB_DRAIN-1:0]  drain_q, drain_d;
    logic [NB_CYCLES-1:0] cycle_count_q;
    logic                 active;
    logic                 redirect;
    logic [NB_ADDR-1:0]   pc_inc;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                // run wins over step when both arrive together
                if (run_i) begin
                    state_d = ST_RUN;
                end else if (step_i) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (halt_i) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            ST_STEP: begin
                // a stalled step is retried until the PC actually advances once
                if (halt_i) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (!stall_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            drain_q       <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (pipe_enable_o) begin
                cycle_count_q <= cycle_count_q + NB_CYCLES'(1);
            end
        end
    end

    always_comb begin
        active   = (state_q == ST_RUN) || (state_q == ST_STEP);
        redirect = pc_bus.jump_i || pc_bus.branch_taken_i;
        pc_inc   = pc_bus.pc_addr_i + NB_ADDR'(PC_INC);

        // Redirects only steer the next address while executing; elsewhere
        // (including reset, which forces IDLE) the sequential address is shown.
        if (active && pc_bus.jump_i) begin
            pc_bus.pc_next_o = pc_bus.jump_addr_i;
        end else if (active && pc_bus.branch_taken_i) begin
            pc_bus.pc_next_o = pc_bus.branch_addr_i;
        end else begin
            pc_bus.pc_next_o = pc_inc;
        end

        // PC holds on the HALT address so the debug unit sees where it stopped
        pc_bus.pc_enable_o = active && !stall_i && !halt_i;
        pc_bus.flush_o     = active && redirect && !stall_i;
        pipe_enable_o      = active || (state_q == ST_DRAIN);
        running_o          = active || (state_q == ST_DRAIN);
        done_o             = (state_q == ST_DONE);
        cycle_count_o      = cycle_count_q;
    end

endmodule
